alu_exec_stage: RTL and testbench

//  Execute-side consumer of the 3-bit ALUControl code produced by the ALU decoder.
//  A registered, back-pressurable ALU stage between decode and memory/cache.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_core.sv | 30 +++
 rtl/alu_exec_stage.sv | 131 +++++++++++++
 tb/tb_alu_exec_stage.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, handshake states and op legality helper
package alu_pkg;

  // ALUControl encodings shared with the ALU decoder
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Handshake state is simply {out_valid, skid_valid}
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_TWO   = 2'b11;

  function automatic logic is_legal_alu_op(input logic [2:0] code);
    case (code)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: is_legal_alu_op = 1'b1;
      default:                                     is_legal_alu_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: op code and operands to result, zero and illegal flags
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  // Evaluate the op; illegal codes yield a zero result so zero reads 1
  always_comb begin
    result  = '0;
    illegal = ~is_legal_alu_op(alu_control);
    case (alu_control)
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - registered ALU stage with a 2-entry skid buffer and valid/ready handshakes
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             illegal_op
);

  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_illegal;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .alu_control (ALUControl),
    .src_a       (SrcA),
    .src_b       (SrcB),
    .result      (core_result),
    .zero        (core_zero),
    .illegal     (core_illegal)
  );

  logic             out_valid_q,   out_valid_d;
  logic [WIDTH-1:0] out_result_q,  out_result_d;
  logic             out_zero_q,    out_zero_d;
  logic             out_illegal_q, out_illegal_d;
  logic             skid_valid_q,  skid_valid_d;
  logic [WIDTH-1:0] skid_result_q, skid_result_d;
  logic             skid_zero_q,   skid_zero_d;
  logic             skid_illegal_q, skid_illegal_d;
  logic             in_ready_q,    in_ready_d;

  logic accept;
  logic drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  // Next-state for OUT/SKID; ready is precomputed from next skid occupancy so it stays a flop
  always_comb begin
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_zero_d     = out_zero_q;
    out_illegal_d  = out_illegal_q;
    skid_valid_d   = skid_valid_q;
    skid_result_d  = skid_result_q;
    skid_zero_d    = skid_zero_q;
    skid_illegal_d = skid_illegal_q;
    case ({out_valid_q, skid_valid_q})
      ST_EMPTY: begin
        if (accept) begin
          out_valid_d   = 1'b1;
          out_result_d  = core_result;
          out_zero_d    = core_zero;
          out_illegal_d = core_illegal;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          out_result_d  = core_result;
          out_zero_d    = core_zero;
          out_illegal_d = core_illegal;
        end else if (accept) begin
          skid_valid_d   = 1'b1;
          skid_result_d  = core_result;
          skid_zero_d    = core_zero;
          skid_illegal_d = core_illegal;
        end else if (drain) begin
          out_valid_d = 1'b0;
        end
      end
      ST_TWO: begin
        if (drain) begin
          out_result_d  = skid_result_q;
          out_zero_d    = skid_zero_q;
          out_illegal_d = skid_illegal_q;
          skid_valid_d  = 1'b0;
        end
      end
      default: begin
        // Skid full with OUT empty cannot occur; fall back to empty
        out_valid_d  = 1'b0;
        skid_valid_d = 1'b0;
      end
    endcase
    in_ready_d = ~skid_valid_d;
  end

  // State registers with synchronous clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_zero_q     <= 1'b0;
      out_illegal_q  <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_result_q  <= '0;
      skid_zero_q    <= 1'b0;
      skid_illegal_q <= 1'b0;
      in_ready_q     <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_zero_q     <= out_zero_d;
      out_illegal_q  <= out_illegal_d;
      skid_valid_q   <= skid_valid_d;
      skid_result_q  <= skid_result_d;
      skid_zero_q    <= skid_zero_d;
      skid_illegal_q <= skid_illegal_d;
      in_ready_q     <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign ALUResult  = out_result_q;
  assign Zero       = out_zero_q;
  assign illegal_op = out_illegal_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - scoreboard bench for alu_exec_stage
module tb_alu_exec_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  ALUControl = 3'b000;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        illegal_op;

  alu_exec_stage #(.WIDTH(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .illegal_op (illegal_op)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t cur_exp;
  int   checks = 0;
  int   passes = 0;
  int   consumed = 0;
  logic mon_en = 1'b0;
  logic rst_sampled = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge CLK) rst_sampled <= RST;

  // Monitor: model occupancy, compare the head entry, pop on drain, push on accept
  always @(negedge CLK) begin
    if (mon_en) begin
      if (rst_sampled) begin
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
        chk("rst_result", {32'b0, ALUResult}, 64'd0);
        chk("rst_flags", {62'b0, Zero, illegal_op}, 64'd0);
        q.delete();
      end else begin
        chk("in_ready", {63'b0, in_ready}, {63'b0, (q.size() < 2)});
        chk("out_valid", {63'b0, out_valid}, {63'b0, (q.size() != 0)});
        if (out_valid && q.size() != 0) begin
          chk("result", {32'b0, ALUResult}, {32'b0, q[0].res});
          chk("zero", {63'b0, Zero}, {63'b0, q[0].zero});
          chk("illegal", {63'b0, illegal_op}, {63'b0, q[0].ill});
          if (out_ready && !RST) begin
            void'(q.pop_front());
            consumed++;
          end
        end
        if (in_valid && in_ready && !RST) q.push_back(cur_exp);
      end
    end
  end

  // Present one op and hold it until accepted; called just after a rising edge
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic z, input logic il);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    ALUControl = op;
    SrcA = a;
    SrcB = b;
    cur_exp = '{res: res, zero: z, ill: il};
    in_valid = 1'b1;
    while (!acc && n < 20) begin
      @(negedge CLK);
      acc = in_ready;
      @(posedge CLK);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    SrcA = 'x;
    SrcB = 'x;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1 reset held 3 cycles
    RST = 1'b1;
    out_ready = 1'b1;
    @(posedge CLK);
    #1 mon_en = 1'b1;
    idle(2);
    RST = 1'b0;
    idle(2);

    // 2 back-to-back stream
    send(3'b000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    send(3'b001, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0);
    send(3'b010, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0);
    send(3'b011, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);
    idle(2);

    // 3 slt both ways, sub to zero
    send(3'b101, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    send(3'b101, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
    send(3'b001, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
    idle(2);

    // 4 back-pressure: two fill OUT/SKID, third waits for drain
    out_ready = 1'b0;
    send(3'b000, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    send(3'b011, 32'hA, 32'h5, 32'hF, 1'b0, 1'b0);
    fork
      send(3'b010, 32'hFF, 32'h0F, 32'h0F, 1'b0, 1'b0);
      begin
        idle(4);
        out_ready = 1'b1;
      end
    join
    idle(3);

    // 5 illegal code then legal op
    send(3'b110, 32'h1234, 32'h5678, 32'd0, 1'b1, 1'b1);
    send(3'b000, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);
    idle(2);

    // 6 reset while two results are held
    out_ready = 1'b0;
    send(3'b000, 32'd100, 32'd1, 32'd101, 1'b0, 1'b0);
    send(3'b001, 32'd50, 32'd8, 32'd42, 1'b0, 1'b0);
    idle(1);
    RST = 1'b1;
    out_ready = 1'b1;
    idle(2);
    RST = 1'b0;
    idle(3);
    send(3'b000, 32'd7, 32'd8, 32'd15, 1'b0, 1'b0);
    idle(3);

    chk("consumed_count", 64'(consumed), 64'd13);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
